// File: rtl/branch_ctrl_pkg.sv
// Shared types, default widths and helpers for the branch controller slice.
// Package name x9_ctrl_pkg is the one other control blocks import.
package x9_ctrl_pkg;

  localparam int unsigned A_DEF  = 4;
  localparam int unsigned L_DEF  = 3;
  localparam int unsigned CW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Decode/fetch-side signal bundle of branch_ctrl; master is the controller.
// Optional BRANCH_CTRL_STATS_EN adds branch_count/taken_count.
interface branch_ctrl_if
  import x9_ctrl_pkg::*;
#(
  parameter int unsigned A  = A_DEF,
  parameter int unsigned L  = L_DEF,
  parameter int unsigned CW = CW_DEF
);

  logic          start;
  logic [A-1:0]  start_addr;
  logic          inst_is_branch;
  logic          branch_cond;
  logic [L-1:0]  lut_idx;
  logic          inst_is_halt;
  logic          lut_we;
  logic [L-1:0]  lut_waddr;
  logic [A-1:0]  lut_wdata;

  logic          if_load;
  logic          ctrl_branch;
  logic          take_branch;
  logic [A-1:0]  inst_addr_out;
  logic          halt;
  logic          done;
  logic [CW-1:0] cycle_count;
`ifdef BRANCH_CTRL_STATS_EN
  logic [CW-1:0] branch_count;
  logic [CW-1:0] taken_count;
`endif

  modport master (
    input  start, start_addr, inst_is_branch, branch_cond, lut_idx,
           inst_is_halt, lut_we, lut_waddr, lut_wdata,
`ifdef BRANCH_CTRL_STATS_EN
    output branch_count, taken_count,
`endif
    output if_load, ctrl_branch, take_branch, inst_addr_out, halt, done,
           cycle_count
  );

  modport slave (
    output start, start_addr, inst_is_branch, branch_cond, lut_idx,
           inst_is_halt, lut_we, lut_waddr, lut_wdata,
`ifdef BRANCH_CTRL_STATS_EN
    input  branch_count, taken_count,
`endif
    input  if_load, ctrl_branch, take_branch, inst_addr_out, halt, done,
           cycle_count
  );

endinterface

// File: rtl/branch_ctrl_lut.sv
// branch_lut: 2**L x A branch target register file.
// Synchronous write and reset, asynchronous read (old data on same-cycle write).
module branch_lut
  import x9_ctrl_pkg::*;
#(
  parameter int unsigned A = A_DEF,
  parameter int unsigned L = L_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [L-1:0] waddr,
  input  logic [A-1:0] wdata,
  input  logic [L-1:0] raddr,
  output logic [A-1:0] rdata
);

  logic [A-1:0] mem_q [2**L];
  logic [A-1:0] mem_d [2**L];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2**L; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: sequences program start/halt/done for the fetch unit and
// resolves branch targets via branch_lut. `define BRANCH_CTRL_STATS_EN adds branch stats.
module branch_ctrl
  import x9_ctrl_pkg::*;
#(
  parameter int unsigned A  = A_DEF,
  parameter int unsigned L  = L_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  branch_ctrl_if.master bus
);

  state_e        state_q, state_d;
  logic [A-1:0]  saddr_q, saddr_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [A-1:0]  lut_rdata;
  logic          start_ok;
  logic          in_run;
  logic          br_fire;
`ifdef BRANCH_CTRL_STATS_EN
  logic [CW-1:0] brc_q, brc_d;
  logic [CW-1:0] tkc_q, tkc_d;
`endif

  branch_lut #(.A(A), .L(L)) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (bus.lut_we),
    .waddr (bus.lut_waddr),
    .wdata (bus.lut_wdata),
    .raddr (bus.lut_idx),
    .rdata (lut_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (bus.inst_is_halt) state_d = DONE;
      DONE:    if (bus.start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Halt in RUN is combinational so the PC holds in the halting cycle.
  always_comb begin
    bus.if_load       = 1'b0;
    bus.ctrl_branch   = 1'b0;
    bus.take_branch   = 1'b0;
    bus.inst_addr_out = '0;
    bus.halt          = 1'b1;
    bus.done          = 1'b0;
    case (state_q)
      LOAD: begin
        bus.if_load       = 1'b1;
        bus.halt          = 1'b0;
        bus.inst_addr_out = saddr_q;
      end
      RUN: begin
        bus.ctrl_branch   = bus.inst_is_branch & ~bus.inst_is_halt;
        bus.take_branch   = bus.branch_cond;
        bus.inst_addr_out = lut_rdata;
        bus.halt          = bus.inst_is_halt;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    start_ok = bus.start & ((state_q == IDLE) | (state_q == DONE));
    in_run   = (state_q == RUN);
    br_fire  = in_run & bus.inst_is_branch & ~bus.inst_is_halt;
    saddr_d  = start_ok ? bus.start_addr : saddr_q;
    cyc_d    = cyc_q;
    if (start_ok)    cyc_d = '0;
    else if (in_run) cyc_d = CW'(sat_inc(32'(cyc_q), CW));
`ifdef BRANCH_CTRL_STATS_EN
    brc_d = brc_q;
    tkc_d = tkc_q;
    if (start_ok) begin
      brc_d = '0;
      tkc_d = '0;
    end else if (br_fire) begin
      brc_d = CW'(sat_inc(32'(brc_q), CW));
      if (bus.branch_cond) tkc_d = CW'(sat_inc(32'(tkc_q), CW));
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      saddr_q <= '0;
      cyc_q   <= '0;
`ifdef BRANCH_CTRL_STATS_EN
      brc_q   <= '0;
      tkc_q   <= '0;
`endif
    end else begin
      saddr_q <= saddr_d;
      cyc_q   <= cyc_d;
`ifdef BRANCH_CTRL_STATS_EN
      brc_q   <= brc_d;
      tkc_q   <= tkc_d;
`endif
    end
  end

  assign bus.cycle_count = cyc_q;
`ifdef BRANCH_CTRL_STATS_EN
  assign bus.branch_count = brc_q;
  assign bus.taken_count  = tkc_q;
`else
  logic unused_br_fire;
  assign unused_br_fire = br_fire;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: a CW=16 and a CW=4 instance share stimulus
// and are checked against a phase/array reference model.
module tb_branch_ctrl;

  localparam int unsigned A   = 4;
  localparam int unsigned L   = 3;
  localparam int unsigned CW  = 16;
  localparam int unsigned CWS = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         t_start = 1'b0;
  logic [A-1:0] t_sa = '0;
  logic         t_br = 1'b0, t_cond = 1'b0, t_h = 1'b0, t_we = 1'b0;
  logic [L-1:0] t_idx = '0, t_wa = '0;
  logic [A-1:0] t_wd = '0;

  branch_ctrl_if #(.A(A), .L(L), .CW(CW))  bus ();
  branch_ctrl_if #(.A(A), .L(L), .CW(CWS)) sbus ();

  assign bus.start = t_start;          assign sbus.start = t_start;
  assign bus.start_addr = t_sa;        assign sbus.start_addr = t_sa;
  assign bus.inst_is_branch = t_br;    assign sbus.inst_is_branch = t_br;
  assign bus.branch_cond = t_cond;     assign sbus.branch_cond = t_cond;
  assign bus.lut_idx = t_idx;          assign sbus.lut_idx = t_idx;
  assign bus.inst_is_halt = t_h;       assign sbus.inst_is_halt = t_h;
  assign bus.lut_we = t_we;            assign sbus.lut_we = t_we;
  assign bus.lut_waddr = t_wa;         assign sbus.lut_waddr = t_wa;
  assign bus.lut_wdata = t_wd;         assign sbus.lut_wdata = t_wd;

  branch_ctrl #(.A(A), .L(L), .CW(CW))  dut   (.clk(clk), .reset(reset), .bus(bus));
  branch_ctrl #(.A(A), .L(L), .CW(CWS)) dut_s (.clk(clk), .reset(reset), .bus(sbus));

  // Reference model
  typedef enum {P_IDLE, P_LOAD, P_RUN, P_DONE} phase_t;
  phase_t       ph = P_IDLE;
  logic [A-1:0] m_lut [2**L];
  logic [A-1:0] m_saddr = '0;
  int unsigned  m_cyc = 0, m_br = 0, m_tk = 0;
  logic         e_load, e_cb, e_tb, e_halt, e_done;
  logic [A-1:0] e_addr;
  int unsigned  n_vec = 0, n_err = 0;

  function automatic int unsigned capped(input int unsigned v, input int unsigned w);
    int unsigned mx;
    mx = (32'd1 << w) - 32'd1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_edge();
    if (reset) begin
      ph = P_IDLE; m_cyc = 0; m_br = 0; m_tk = 0; m_saddr = '0;
      for (int k = 0; k < 2**L; k++) m_lut[k] = '0;
    end else begin
      if (ph == P_RUN) begin
        m_cyc++;
        if (t_br && !t_h) begin
          m_br++;
          if (t_cond) m_tk++;
        end
      end
      if (t_we) m_lut[t_wa] = t_wd;
      case (ph)
        P_IDLE, P_DONE: if (t_start) begin
          ph = P_LOAD; m_saddr = t_sa; m_cyc = 0; m_br = 0; m_tk = 0;
        end
        P_LOAD: ph = P_RUN;
        P_RUN:  if (t_h) ph = P_DONE;
        default: ;
      endcase
    end
  endtask

  task automatic settle();
    #1;
    e_load = 1'b0; e_cb = 1'b0; e_tb = 1'b0; e_addr = '0; e_halt = 1'b1; e_done = 1'b0;
    case (ph)
      P_LOAD: begin e_load = 1'b1; e_halt = 1'b0; e_addr = m_saddr; end
      P_RUN: begin
        e_halt = t_h; e_cb = t_br & ~t_h; e_tb = t_cond; e_addr = m_lut[t_idx];
      end
      P_DONE: e_done = 1'b1;
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_in();
    t_start = 1'b0; t_br = 1'b0; t_cond = 1'b0; t_h = 1'b0; t_we = 1'b0;
  endtask

  task automatic test_reset();
    idle_in(); reset = 1'b1;
    tick(); tick();
    settle();
    n_vec++;
    if ({bus.halt, bus.done, bus.if_load, bus.ctrl_branch, bus.take_branch, bus.inst_addr_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}) begin
      n_err++; $display("FAIL reset_outputs: got h%b d%b l%b cb%b tb%b a%h", bus.halt, bus.done, bus.if_load, bus.ctrl_branch, bus.take_branch, bus.inst_addr_out);
    end
    n_vec++;
    if (bus.cycle_count !== 16'd0) begin
      n_err++; $display("FAIL reset_count: got %0d want 0", bus.cycle_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_start_load();
    t_start = 1'b1; t_sa = 4'h3; settle(); tick();
    t_start = 1'b0; settle();
    n_vec++;
    if ({bus.if_load, bus.halt, bus.inst_addr_out} !== {1'b1, 1'b0, 4'h3}) begin
      n_err++; $display("FAIL load_cycle: got load=%b halt=%b addr=%h want 1 0 3", bus.if_load, bus.halt, bus.inst_addr_out);
    end
    tick(); settle();
    n_vec++;
    if ({bus.if_load, bus.halt, bus.done} !== 3'b000) begin
      n_err++; $display("FAIL run_entry: got load=%b halt=%b done=%b want 0 0 0", bus.if_load, bus.halt, bus.done);
    end
    tick();
  endtask

  task automatic test_branch_taken();
    t_we = 1'b1; t_wa = 3'd2; t_wd = 4'hA; settle(); tick();
    t_we = 1'b0; t_br = 1'b1; t_cond = 1'b1; t_idx = 3'd2; settle();
    n_vec++;
    if ({bus.ctrl_branch, bus.take_branch, bus.inst_addr_out, bus.halt} !== {1'b1, 1'b1, 4'hA, 1'b0}) begin
      n_err++; $display("FAIL branch_taken: got cb=%b tb=%b addr=%h halt=%b want 1 1 a 0", bus.ctrl_branch, bus.take_branch, bus.inst_addr_out, bus.halt);
    end
    tick();
  endtask

  task automatic test_branch_not_taken();
    t_br = 1'b1; t_cond = 1'b0; t_idx = 3'd2; settle();
    n_vec++;
    if ({bus.ctrl_branch, bus.take_branch, bus.halt} !== 3'b100) begin
      n_err++; $display("FAIL branch_not_taken: got cb=%b tb=%b halt=%b want 1 0 0", bus.ctrl_branch, bus.take_branch, bus.halt);
    end
    tick();
  endtask

  task automatic test_lut_rbw();
    t_br = 1'b0; t_we = 1'b1; t_wa = 3'd1; t_wd = 4'h7; t_idx = 3'd1; settle();
    n_vec++;
    if (bus.inst_addr_out !== e_addr || e_addr === 4'h7) begin
      n_err++; $display("FAIL lut_rbw_old: got %h want %h", bus.inst_addr_out, e_addr);
    end
    tick();
    t_we = 1'b0; settle();
    n_vec++;
    if (bus.inst_addr_out !== 4'h7) begin
      n_err++; $display("FAIL lut_rbw_new: got %h want 7", bus.inst_addr_out);
    end
    tick();
  endtask

  task automatic test_halt();
    int unsigned held;
    t_h = 1'b1; t_br = 1'b1; t_cond = 1'b1; settle();
    n_vec++;
    if ({bus.halt, bus.ctrl_branch} !== 2'b10) begin
      n_err++; $display("FAIL halt_beats_branch: got halt=%b cb=%b want 1 0", bus.halt, bus.ctrl_branch);
    end
    tick(); idle_in(); held = m_cyc;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_vec++;
      if ({bus.done, bus.halt} !== 2'b11 || bus.cycle_count !== CW'(held)) begin
        n_err++; $display("FAIL done_hold: got done=%b halt=%b cnt=%0d want 1 1 %0d", bus.done, bus.halt, bus.cycle_count, held);
      end
      tick();
    end
  endtask

  task automatic test_restart();
    t_start = 1'b1; t_sa = 4'h5; settle(); tick();
    t_start = 1'b0; settle();
    n_vec++;
    if ({bus.if_load, bus.inst_addr_out, bus.done} !== {1'b1, 4'h5, 1'b0} || bus.cycle_count !== 16'd0) begin
      n_err++; $display("FAIL restart: got load=%b addr=%h done=%b cnt=%0d want 1 5 0 0", bus.if_load, bus.inst_addr_out, bus.done, bus.cycle_count);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    for (int c = 0; c < 3; c++) begin
      t_br = 1'(($urandom_range(1))); t_cond = 1'(($urandom_range(1))); settle(); tick();
    end
    idle_in(); reset = 1'b1; settle(); tick();
    reset = 1'b0; settle();
    n_vec++;
    if ({bus.halt, bus.done, bus.if_load} !== 3'b100 || bus.cycle_count !== 16'd0) begin
      n_err++; $display("FAIL reset_mid_run: got halt=%b done=%b load=%b cnt=%0d want 1 0 0 0", bus.halt, bus.done, bus.if_load, bus.cycle_count);
    end
    t_start = 1'b1; t_sa = 4'h0; settle(); tick();
    t_start = 1'b0; settle(); tick();
    t_br = 1'b1; t_cond = 1'b1; t_idx = 3'd2; settle();
    n_vec++;
    if (bus.inst_addr_out !== 4'h0) begin
      n_err++; $display("FAIL lut_cleared: got LUT[2]=%h want 0", bus.inst_addr_out);
    end
    tick(); idle_in();
  endtask

  task automatic test_saturation();
    reset = 1'b1; settle(); tick(); reset = 1'b0;
    t_start = 1'b1; t_sa = 4'h1; settle(); tick();
    t_start = 1'b0; settle(); tick();
    for (int c = 0; c < 20; c++) begin settle(); tick(); end
    settle();
    n_vec++;
    if (sbus.cycle_count !== 4'd15) begin
      n_err++; $display("FAIL saturate_cw4: got %0d want 15", sbus.cycle_count);
    end
    n_vec++;
    if (bus.cycle_count !== 16'd20) begin
      n_err++; $display("FAIL count_cw16: got %0d want 20", bus.cycle_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(79) == 0);
      t_start = ($urandom_range(5) == 0);
      t_sa    = A'($urandom);
      t_br    = 1'($urandom_range(1));
      t_cond  = 1'($urandom_range(1));
      t_idx   = L'($urandom);
      t_h     = ($urandom_range(11) == 0);
      t_we    = ($urandom_range(3) == 0);
      t_wa    = L'($urandom);
      t_wd    = A'($urandom);
      settle();
      n_vec++;
      if ({bus.if_load, bus.ctrl_branch, bus.take_branch, bus.inst_addr_out, bus.halt, bus.done} !== {e_load, e_cb, e_tb, e_addr, e_halt, e_done}) begin
        n_err++; $display("FAIL rand_out[%0d]: got %b want %b", i, {bus.if_load, bus.ctrl_branch, bus.take_branch, bus.inst_addr_out, bus.halt, bus.done}, {e_load, e_cb, e_tb, e_addr, e_halt, e_done});
      end
      n_vec++;
      if ({sbus.if_load, sbus.ctrl_branch, sbus.take_branch, sbus.inst_addr_out, sbus.halt, sbus.done} !== {e_load, e_cb, e_tb, e_addr, e_halt, e_done}) begin
        n_err++; $display("FAIL rand_out_s[%0d]: got %b want %b", i, {sbus.if_load, sbus.ctrl_branch, sbus.take_branch, sbus.inst_addr_out, sbus.halt, sbus.done}, {e_load, e_cb, e_tb, e_addr, e_halt, e_done});
      end
      n_vec++;
      if (bus.cycle_count !== CW'(capped(m_cyc, CW)) || sbus.cycle_count !== CWS'(capped(m_cyc, CWS))) begin
        n_err++; $display("FAIL rand_count[%0d]: got %0d/%0d want %0d/%0d", i, bus.cycle_count, sbus.cycle_count, capped(m_cyc, CW), capped(m_cyc, CWS));
      end
`ifdef BRANCH_CTRL_STATS_EN
      n_vec++;
      if (bus.branch_count !== CW'(capped(m_br, CW)) || bus.taken_count !== CW'(capped(m_tk, CW)) ||
          sbus.branch_count !== CWS'(capped(m_br, CWS)) || sbus.taken_count !== CWS'(capped(m_tk, CWS))) begin
        n_err++; $display("FAIL rand_stats[%0d]: got br=%0d tk=%0d brs=%0d tks=%0d want %0d %0d", i, bus.branch_count, bus.taken_count, sbus.branch_count, sbus.taken_count, m_br, m_tk);
      end
`endif
      tick();
    end
    reset = 1'b0; idle_in();
  endtask

  initial begin
    for (int k = 0; k < 2**L; k++) m_lut[k] = '0;
    @(negedge clk);
    test_reset();
    test_start_load();
    test_branch_taken();
    test_branch_not_taken();
    test_lut_rbw();
    test_halt();
    test_restart();
    test_reset_mid_run();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Control-side counterpart of the instruction-fetch PC unit. Drives its load, branch, take-branch, target-address and halt inputs.
- Sequences program start, halt and completion.
- Resolves branch targets through a small writable target lookup table (LUT) indexed by the instruction's branch field.
- Sits between decode/ALU flags and the fetch unit; counts executed cycles.

Parameters:
- A, 4, instruction address width; matches the fetch unit.
- L, 3, LUT index width; the LUT has 2**L entries of A bits.
- CW, 16, cycle counter width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse: begin execution at start_addr.
- start_addr  input  A  program entry address.
- inst_is_branch  input  1  decoded current instruction is a conditional branch.
- branch_cond  input  1  branch condition flag from the ALU/flags.
- lut_idx  input  L  branch target index from the current instruction.
- inst_is_halt  input  1  decoded current instruction is halt.
- lut_we  input  1  LUT write enable.
- lut_waddr  input  L  LUT write index.
- lut_wdata  input  A  LUT write data.
- if_load  output  1  drives the fetch unit's reset/load pin.
- ctrl_branch  output  1  to fetch unit.
- take_branch  output  1  to fetch unit.
- inst_addr_out  output  A  to the fetch unit's address input (start address or branch target).
- halt  output  1  to fetch unit; freezes the PC.
- done  output  1  program finished.
- cycle_count  output  CW  cycles spent in RUN.

Behaviour:
- State machine states: IDLE, LOAD, RUN, DONE. Encoding is 2-bit.
- On reset:
  - state = IDLE; cycle_count = 0; all LUT entries = 0.
  - Outputs: halt = 1, done = 0, if_load = 0, ctrl_branch = 0, take_branch = 0, inst_addr_out = 0.
- IDLE:
  - halt = 1.
  - start=1 -> LOAD next cycle; start_addr is captured into a register on that edge.
- LOAD (exactly 1 cycle):
  - if_load = 1, halt = 0, inst_addr_out = captured start address.
  - The fetch PC equals the start address after this edge.
  - Next state is RUN.
- RUN:
  - ctrl_branch = inst_is_branch & ~inst_is_halt.
  - take_branch = branch_cond.
  - inst_addr_out = LUT[lut_idx], combinational read.
  - halt = 0.
  - Resolution latency is zero cycles: the PC holds the target on the next edge.
  - cycle_count increments each RUN cycle and saturates at all-ones (no wrap).
- RUN, inst_is_halt=1:
  - halt asserts combinationally in that same cycle, so the PC holds.
  - Halt beats a simultaneous branch: ctrl_branch is forced 0.
  - Next state is DONE.
- DONE:
  - halt = 1, done = 1; cycle_count frozen.
  - start=1 -> LOAD; cycle_count clears to 0 on that edge.
- start in LOAD or RUN: ignored.
- inst_is_branch/inst_is_halt outside RUN: ignored.
- LUT:
  - Written on posedge when lut_we=1, in any state.
  - Same-cycle write and read of the same index returns the old entry (read-before-write).
- Reset mid-RUN: returns to IDLE next edge and clears the counter and LUT; done = 0.
- inst_addr_out in IDLE/DONE = 0.

Optional Feature:
- Macro: BRANCH_CTRL_STATS_EN.
- When defined:
  - Adds outputs branch_count (CW) and taken_count (CW).
  - branch_count counts RUN cycles with ctrl_branch=1; taken_count counts those that also have take_branch=1.
  - Both are saturating, cleared by reset and by start accepted in IDLE/DONE, and frozen outside RUN.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package x9_ctrl_pkg holds:
  - state enum typedef (IDLE, LOAD, RUN, DONE);
  - default widths A/L/CW as localparams;
  - a saturating-increment function.
- One natural sub-module: branch_lut. It is the 2**L x A register file: synchronous write, asynchronous read, synchronous reset to 0.

Test Plan:
- Reset, then start=1 with start_addr=4'h3 -> LOAD asserts if_load=1 and inst_addr_out=3 for one cycle; then RUN with halt=0.
- Write LUT[2]=4'hA; in RUN drive inst_is_branch=1, branch_cond=1, lut_idx=2 -> ctrl_branch=1, take_branch=1, inst_addr_out=A in the same cycle.
- In RUN drive inst_is_branch=1, branch_cond=0 -> ctrl_branch=1, take_branch=0; the fetch PC increments.
- In RUN drive inst_is_halt=1 and inst_is_branch=1 together -> halt=1, ctrl_branch=0; next cycle done=1 and cycle_count stays fixed (e.g. 5 after 5 RUN cycles).
- Write LUT[1]=4'h7 while reading lut_idx=1 in the same cycle -> old value seen; 7 seen next cycle.
- Assert reset mid-RUN -> next cycle state IDLE, halt=1, done=0, cycle_count=0, LUT[2] reads 0. With CW=4, run 20 cycles -> cycle_count saturates at 15.
